// File: rtl/timer_bank.sv
// Bank of NCH down-counting timers sharing one programmable prescaler.
// Each channel runs periodic (auto-reload) or one-shot and raises a one-cycle expiry pulse.
//
// state   | meaning
// --------+--------------------------------------------------------------
// ST_RUN  | armed; counts down on enabled ticks, expires at terminal count 0
// ST_DONE | one-shot expired; counter holds at 0 until the next load
module timer_bank #(
    parameter int NCH = 4,
    parameter int W   = 8,
    parameter int PW  = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [PW-1:0]    prescale,
    input  logic [NCH*W-1:0] load_value,
    input  logic [NCH-1:0]   load,
    input  logic [NCH-1:0]   count_en,
    input  logic [NCH-1:0]   mode,
    output logic [NCH-1:0]   out,
    output logic [NCH-1:0]   running,
    output logic [NCH*W-1:0] cur_count
);

    localparam logic ST_RUN  = 1'b0;
    localparam logic ST_DONE = 1'b1;

    logic [PW-1:0] pre_cnt;
    logic          tick;

    // >= rather than == so a prescale shrunk below pre_cnt ticks at once instead of wrapping
    assign tick = (pre_cnt >= prescale);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pre_cnt <= '0;
        end else if (tick) begin
            pre_cnt <= '0;
        end else begin
            pre_cnt <= pre_cnt + PW'(1);
        end
    end

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        logic [W-1:0] cur;
        logic         state;
        logic         step;
        logic         expire;

        assign step   = (state == ST_RUN) && count_en[g] && tick && !load[g];
        assign expire = step && (cur == '0);

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                cur   <= '0;
                state <= ST_RUN;
            end else if (load[g]) begin
                cur   <= load_value[g*W +: W];
                state <= ST_RUN;
            end else if (expire) begin
                if (mode[g]) begin
                    state <= ST_DONE;
                end else begin
                    cur <= load_value[g*W +: W];
                end
            end else if (step) begin
                cur <= cur - W'(1);
            end
        end

        // Gated by reset_n so the pulse drops the moment reset asserts, even with cur=0 in RUN
        assign out[g]               = expire && reset_n;
        assign running[g]           = (state == ST_RUN) && count_en[g];
        assign cur_count[g*W +: W]  = cur;
    end

endmodule

// File: tb/tb_timer_bank.sv
// Self-checking bench for timer_bank: directed scenarios plus randomized traffic,
// every cycle compared against a behavioural model of the timer rules.
module tb_timer_bank;
    localparam int NCH = 4;
    localparam int W   = 8;
    localparam int PW  = 8;

    logic             clk = 1'b0;
    logic             reset_n;
    logic [PW-1:0]    prescale;
    logic [NCH*W-1:0] load_value;
    logic [NCH-1:0]   load;
    logic [NCH-1:0]   count_en;
    logic [NCH-1:0]   mode;
    logic [NCH-1:0]   out;
    logic [NCH-1:0]   running;
    logic [NCH*W-1:0] cur_count;

    int checks   = 0;
    int failures = 0;

    int m_pre;
    int m_cur [NCH];
    bit m_done[NCH];

    logic [NCH-1:0]   last_out;
    logic [NCH-1:0]   last_run;
    logic [NCH*W-1:0] last_cur;

    timer_bank #(.NCH(NCH), .W(W), .PW(PW)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .prescale   (prescale),
        .load_value (load_value),
        .load       (load),
        .count_en   (count_en),
        .mode       (mode),
        .out        (out),
        .running    (running),
        .cur_count  (cur_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pre = 0;
        for (int i = 0; i < NCH; i++) begin
            m_cur[i]  = 0;
            m_done[i] = 1'b0;
        end
    endtask

    task automatic set_lv(input int ch, input int v);
        load_value[ch*W +: W] = W'(v);
    endtask

    function automatic int ch_cur(input int ch);
        return int'(last_cur[ch*W +: W]);
    endfunction

    // Sample at the falling edge, compare with the model, then advance the model
    // by the rising edge that follows. Returns 1 time unit after that rising edge.
    task automatic step();
        logic [NCH-1:0]   e_out;
        logic [NCH-1:0]   e_run;
        logic [NCH*W-1:0] e_cur;
        bit               tk;
        int               lv;
        @(negedge clk);
        tk = reset_n && (m_pre >= int'(prescale));
        for (int i = 0; i < NCH; i++) begin
            e_run[i]         = !m_done[i] && count_en[i];
            e_cur[i*W +: W]  = W'(m_cur[i]);
            e_out[i]         = reset_n && !load[i] && !m_done[i] && count_en[i] && tk && (m_cur[i] == 0);
        end
        check("out",       64'(out),       64'(e_out));
        check("running",   64'(running),   64'(e_run));
        check("cur_count", 64'(cur_count), 64'(e_cur));
        last_out = out;
        last_run = running;
        last_cur = cur_count;
        if (!reset_n) begin
            model_reset();
        end else begin
            for (int i = 0; i < NCH; i++) begin
                lv = int'(load_value[i*W +: W]);
                if (load[i]) begin
                    m_cur[i]  = lv;
                    m_done[i] = 1'b0;
                end else if (!m_done[i] && count_en[i] && tk) begin
                    if (m_cur[i] == 0) begin
                        if (mode[i]) m_done[i] = 1'b1;
                        else         m_cur[i]  = lv;
                    end else begin
                        m_cur[i] = m_cur[i] - 1;
                    end
                end
            end
            m_pre = tk ? 0 : m_pre + 1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic power_up_check(input string tag);
        logic [11:0] mask;
        prescale = '0;
        load     = '0;
        count_en = 4'b0001;
        mode     = '0;
        set_lv(0, 3);
        reset_n  = 1'b1;
        for (int k = 0; k < 12; k++) begin
            step();
            mask[k] = last_out[0];
        end
        check(tag, 64'(mask), 64'h111);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int q[$];
        int npulse;
        int pidx;
        bit found;

        reset_n    = 1'b0;
        prescale   = '0;
        load_value = '0;
        load       = '0;
        count_en   = 4'b1111;
        mode       = '0;
        model_reset();
        #2;
        check("rst_cur",     64'(cur_count), 64'h0);
        check("rst_out",     64'(out),       64'h0);
        check("rst_running", 64'(running),   64'hf);
        step();
        step();

        // periodic ch0, load_value 3, pulses at cycles 0,4,8 after reset release
        power_up_check("s1_pulses");

        // prescale=2, ch1 load_value=1 periodic: pulses 6 cycles apart
        count_en = '0;
        prescale = 8'd2;
        set_lv(1, 1);
        load = 4'b0010;
        step();
        load     = '0;
        count_en = 4'b0010;
        q = {};
        for (int k = 0; k < 24; k++) begin
            step();
            if (last_out[1]) q.push_back(k);
        end
        check("s2_npulses", 64'(q.size() >= 3), 64'h1);
        if (q.size() >= 3) begin
            check("s2_period_a", 64'(q[1] - q[0]), 64'd6);
            check("s2_period_b", 64'(q[2] - q[1]), 64'd6);
        end

        // one-shot ch2: 2,1,0, one pulse, then DONE; re-arm with 5
        prescale = '0;
        count_en = '0;
        mode     = 4'b0100;
        set_lv(2, 2);
        load = 4'b0100;
        step();
        load     = '0;
        count_en = 4'b0100;
        npulse = 0;
        pidx   = -1;
        for (int k = 0; k < 8; k++) begin
            step();
            if (last_out[2]) begin
                npulse++;
                pidx = k;
            end
        end
        check("s3_npulse",   64'(npulse),    64'd1);
        check("s3_pidx",     64'(pidx),      64'd2);
        check("s3_cur_done", 64'(ch_cur(2)), 64'd0);
        check("s3_done_run", 64'(last_run[2]), 64'd0);
        set_lv(2, 5);
        load = 4'b0100;
        step();
        load = '0;
        pidx = -1;
        for (int k = 0; k < 10; k++) begin
            step();
            if (last_out[2] && pidx < 0) pidx = k;
        end
        check("s3_rearm_pidx", 64'(pidx), 64'd5);

        // load on the expiry cycle wins: no pulse, cur=7 next cycle
        mode     = '0;
        count_en = 4'b0001;
        set_lv(0, 3);
        load = 4'b0001;
        step();
        load  = '0;
        found = 1'b0;
        for (int k = 0; k < 10 && !found; k++) begin
            step();
            if (ch_cur(0) == 1) found = 1'b1;
        end
        if (!found) check("s4_timeout", 64'h0, 64'h1);
        load = 4'b0001;
        set_lv(0, 7);
        step();
        check("s4_no_pulse", 64'(last_out[0]), 64'h0);
        load = '0;
        step();
        check("s4_cur7", 64'(ch_cur(0)), 64'd7);

        // freeze ch3 at 5 for 10 cycles, then resume at 4
        count_en = 4'b1000;
        set_lv(3, 9);
        load = 4'b1000;
        step();
        load  = '0;
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            step();
            if (ch_cur(3) == 6) found = 1'b1;
        end
        if (!found) check("s5_timeout", 64'h0, 64'h1);
        count_en[3] = 1'b0;
        for (int k = 0; k < 10; k++) begin
            step();
            check("s5_hold",    64'(ch_cur(3)),   64'd5);
            check("s5_running", 64'(last_run[3]), 64'h0);
        end
        count_en[3] = 1'b1;
        step();
        check("s5_resume_a", 64'(ch_cur(3)), 64'd5);
        step();
        check("s5_resume_b", 64'(ch_cur(3)), 64'd4);

        // asynchronous reset between edges while counting
        count_en = 4'b0001;
        set_lv(0, 200);
        load = 4'b0001;
        step();
        load = '0;
        step();
        step();
        step();
        #2 reset_n = 1'b0;
        #1;
        check("s6_cur", 64'(cur_count), 64'h0);
        check("s6_out", 64'(out),       64'h0);
        model_reset();
        step();
        step();
        power_up_check("s6_pulses");

        // randomized traffic against the model
        for (int n = 0; n < 600; n++) begin
            if (n % 60 == 0) prescale = PW'($urandom_range(0, 3));
            for (int i = 0; i < NCH; i++) begin
                set_lv(i, int'($urandom_range(0, 6)));
                load[i]     = ($urandom_range(0, 11) == 0);
                count_en[i] = ($urandom_range(0, 7) != 0);
                if ($urandom_range(0, 19) == 0) mode[i] = ~mode[i];
            end
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
